// File: rtl/cache_sim_pkg.sv
//------------------------------------------------------------------------------
// cache_sim_pkg: shared types for the cache simulator trace path.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cache_sim_pkg;

    typedef logic [15:0] u16;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    localparam int TRACE_ADDR_W = 16;

    typedef struct packed {
        logic                    rw;
        logic [TRACE_ADDR_W-1:0] addr;
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } player_state_t;

endpackage

`default_nettype wire

// File: rtl/trace_buffer.sv
//------------------------------------------------------------------------------
// trace_buffer: simple dual-port trace store, synchronous write, registered read.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trace_buffer
    import cache_sim_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Write-first bypass: a load and a playback start in the same cycle may
    // target the same slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/cache_trace_player.sv
//------------------------------------------------------------------------------
// cache_trace_player: buffers (rw, addr) accesses and replays them to the cache.
// Optional CACHE_TRACE_STATS_EN adds saturating issued read/write counters. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cache_trace_player
    import cache_sim_pkg::*;
#(
    parameter int ADDRESS_SIZE = 16,
    parameter int DEPTH        = 256,
    parameter int LOOPS_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid_i,
    input  logic                     load_rw_i,
    input  logic [ADDRESS_SIZE-1:0]  load_addr_i,
    output logic                     load_ready_o,
    input  logic                     start_i,
    input  logic [LOOPS_WIDTH-1:0]   loops_i,
    input  logic                     pause_i,
    input  logic                     clear_i,
    output logic                     req_valid_o,
    output logic                     req_rw_o,
    output logic [ADDRESS_SIZE-1:0]  req_addr_o,
    input  logic                     req_ready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
`ifdef CACHE_TRACE_STATS_EN
    ,
    output logic [31:0]              issued_reads_o,
    output logic [31:0]              issued_writes_o
`endif
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int CNT_W   = IDX_W + 1;
    localparam int ENTRY_W = ADDRESS_SIZE + 1;

    player_state_t          state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [LOOPS_WIDTH-1:0] loops_q, loops_d;
    logic                   req_valid_q, req_valid_d;
    logic                   overflow_q, overflow_d;

    logic                   buf_we;
    logic                   buf_re;
    logic [IDX_W-1:0]       buf_raddr;
    logic [ENTRY_W-1:0]     buf_rdata;
    logic                   begin_play;

    logic full;
    logic xfer;
    logic last;

    assign full = (count_q == CNT_W'(DEPTH));
    assign xfer = req_valid_q && req_ready_i;
    assign last = ({1'b0, ptr_q} == (count_q - CNT_W'(1)));

    trace_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (buf_we),
        .wr_addr_i (count_q[IDX_W-1:0]),
        .wr_data_i ({load_rw_i, load_addr_i}),
        .rd_en_i   (buf_re),
        .rd_addr_i (buf_raddr),
        .rd_data_o (buf_rdata)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ptr_d       = ptr_q;
        loops_d     = loops_q;
        req_valid_d = req_valid_q;
        overflow_d  = overflow_q;
        buf_we      = 1'b0;
        buf_re      = 1'b0;
        buf_raddr   = '0;
        begin_play  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (clear_i) begin
                    count_d    = '0;
                    overflow_d = 1'b0;
                end else begin
                    if (load_valid_i) begin
                        if (full) begin
                            overflow_d = 1'b1;
                        end else begin
                            buf_we  = 1'b1;
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                    if (start_i) begin
                        if (count_d != '0) begin
                            begin_play = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end

            PLAY: begin
                // The next entry is fetched on the transfer edge so it is
                // already in the read register when req_valid rises again.
                if (xfer) begin
                    if (last) begin
                        if (loops_q > LOOPS_WIDTH'(1)) begin
                            ptr_d       = '0;
                            loops_d     = loops_q - LOOPS_WIDTH'(1);
                            buf_re      = 1'b1;
                            buf_raddr   = '0;
                            req_valid_d = !pause_i;
                        end else begin
                            state_d     = DONE;
                            req_valid_d = 1'b0;
                        end
                    end else begin
                        ptr_d       = ptr_q + IDX_W'(1);
                        buf_re      = 1'b1;
                        buf_raddr   = ptr_d;
                        req_valid_d = !pause_i;
                    end
                end else if (!req_valid_q) begin
                    req_valid_d = !pause_i;
                end
            end

            DONE: begin
                if (clear_i) begin
                    count_d    = '0;
                    overflow_d = 1'b0;
                    state_d    = IDLE;
                end else if (start_i && (count_q != '0)) begin
                    begin_play = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (begin_play) begin
            state_d     = PLAY;
            ptr_d       = '0;
            loops_d     = (loops_i == '0) ? LOOPS_WIDTH'(1) : loops_i;
            buf_re      = 1'b1;
            buf_raddr   = '0;
            req_valid_d = !pause_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            ptr_q       <= '0;
            loops_q     <= '0;
            req_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            loops_q     <= loops_d;
            req_valid_q <= req_valid_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef CACHE_TRACE_STATS_EN
    u32   reads_q;
    u32   writes_q;
    logic stats_clr;

    assign stats_clr = (state_q != PLAY) && start_i && !clear_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reads_q  <= '0;
            writes_q <= '0;
        end else if (stats_clr) begin
            reads_q  <= '0;
            writes_q <= '0;
        end else if (xfer) begin
            if (req_rw_o) begin
                if (writes_q != '1) writes_q <= writes_q + 32'd1;
            end else begin
                if (reads_q != '1) reads_q <= reads_q + 32'd1;
            end
        end
    end

    assign issued_reads_o  = reads_q;
    assign issued_writes_o = writes_q;
`endif

    assign load_ready_o = (state_q == IDLE) && !full;
    assign req_valid_o  = req_valid_q;
    assign req_rw_o     = buf_rdata[ENTRY_W-1];
    assign req_addr_o   = buf_rdata[ADDRESS_SIZE-1:0];
    assign busy_o       = (state_q == PLAY);
    assign done_o       = (state_q == DONE);
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_trace_player.sv
//------------------------------------------------------------------------------
// tb_cache_trace_player: scoreboard bench with a queue-based trace replay model.
//------------------------------------------------------------------------------
`default_nettype none

module tb_cache_trace_player;

    localparam int AW    = 16;
    localparam int DEPTH = 16;
    localparam int LW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid_i, load_rw_i, load_ready_o;
    logic [AW-1:0] load_addr_i;
    logic          start_i, pause_i, clear_i;
    logic [LW-1:0] loops_i;
    logic          req_valid_o, req_rw_o, req_ready_i;
    logic [AW-1:0] req_addr_o;
    logic          busy_o, done_o, overflow_o;
    logic [CW-1:0] count_o;
`ifdef CACHE_TRACE_STATS_EN
    logic [31:0]   issued_reads_o, issued_writes_o;
`endif

    cache_trace_player #(
        .ADDRESS_SIZE (AW),
        .DEPTH        (DEPTH),
        .LOOPS_WIDTH  (LW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid_i (load_valid_i),
        .load_rw_i    (load_rw_i),
        .load_addr_i  (load_addr_i),
        .load_ready_o (load_ready_o),
        .start_i      (start_i),
        .loops_i      (loops_i),
        .pause_i      (pause_i),
        .clear_i      (clear_i),
        .req_valid_o  (req_valid_o),
        .req_rw_o     (req_rw_o),
        .req_addr_o   (req_addr_o),
        .req_ready_i  (req_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o)
`ifdef CACHE_TRACE_STATS_EN
        ,
        .issued_reads_o  (issued_reads_o),
        .issued_writes_o (issued_writes_o)
`endif
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    ent_t trace_m[$];
    ent_t exp_q[$];
    bit   ovf_m = 1'b0;
    int   exp_reads = 0;
    int   exp_writes = 0;
    int   ready_mode = 0;
    int   pause_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Backpressure and pause generator (mode 3 leaves req_ready_i to the main driver)
    initial begin
        req_ready_i = 1'b0;
        pause_i     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       req_ready_i = 1'b1;
                1:       req_ready_i = ($urandom % 3) != 0;
                default: ;
            endcase
            pause_i = (pause_mode != 0) && (($urandom % 4) == 0);
        end
    end

    // Monitor: compares every transfer against the scoreboard and checks handshake rules
    logic          pv, prw, prdy, ppause, pxfer, have;
    logic [AW-1:0] paddr;
    initial have = 1'b0;

    always @(negedge clk) begin
        logic xfer;
        ent_t e;
        if (reset) begin
            have = 1'b0;
        end else begin
            xfer = req_valid_o && req_ready_i;
            if (have && pv && !prdy) begin
                check("hold_valid", 32'(req_valid_o), 32'd1);
                check("hold_data", 32'({req_rw_o, req_addr_o}), 32'({prw, paddr}));
            end
            if (have && !pv && req_valid_o)
                check("pause_gate", 32'(ppause), 32'd0);
            if (have && pxfer) begin
                if (exp_q.size() == 0) begin
                    check("done_after_last", 32'(done_o), 32'd1);
                    check("idle_after_last", 32'(req_valid_o), 32'd0);
                end else if (!ppause) begin
                    check("no_bubble", 32'(req_valid_o), 32'd1);
                end
            end
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 32'(req_valid_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("req_entry", 32'({req_rw_o, req_addr_o}), 32'(e));
                end
            end
            pv     = req_valid_o;
            prw    = req_rw_o;
            paddr  = req_addr_o;
            prdy   = req_ready_i;
            ppause = pause_i;
            pxfer  = xfer;
            have   = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_load(input logic rw, input logic [AW-1:0] a);
        if (trace_m.size() < DEPTH) trace_m.push_back(ent_t'{rw, a});
        else ovf_m = 1'b1;
    endtask

    task automatic model_start(input int l);
        int n;
        n = (l == 0) ? 1 : l;
        exp_reads  = 0;
        exp_writes = 0;
        for (int k = 0; k < n; k++) begin
            foreach (trace_m[i]) begin
                exp_q.push_back(trace_m[i]);
                if (trace_m[i].rw) exp_writes++;
                else exp_reads++;
            end
        end
    endtask

    task automatic load(input logic rw, input logic [AW-1:0] a);
        check("load_ready", 32'(load_ready_o), 32'(trace_m.size() < DEPTH));
        load_valid_i = 1'b1;
        load_rw_i    = rw;
        load_addr_i  = a;
        model_load(rw, a);
        step();
        load_valid_i = 1'b0;
    endtask

    task automatic start_play(input int l);
        start_i = 1'b1;
        loops_i = LW'(l);
        model_start(l);
        step();
        start_i = 1'b0;
    endtask

    task automatic load_start(input logic rw, input logic [AW-1:0] a, input int l);
        load_valid_i = 1'b1;
        load_rw_i    = rw;
        load_addr_i  = a;
        model_load(rw, a);
        start_i = 1'b1;
        loops_i = LW'(l);
        model_start(l);
        step();
        load_valid_i = 1'b0;
        start_i      = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        trace_m.delete();
        ovf_m = 1'b0;
        check("clear_count", 32'(count_o), 32'd0);
        check("clear_done", 32'(done_o), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        trace_m.delete();
        exp_q.delete();
        ovf_m = 1'b0;
        step();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_o && n < 3000) begin
            step();
            n++;
        end
        check("done_reached", 32'(done_o), 32'd1);
        if (!done_o) begin
            do_reset();
        end else begin
            step();
            check("queue_drained", 32'(exp_q.size()), 32'd0);
            check("busy_low", 32'(busy_o), 32'd0);
            check("count", 32'(count_o), 32'(trace_m.size()));
            check("overflow", 32'(overflow_o), 32'(ovf_m));
`ifdef CACHE_TRACE_STATS_EN
            check("stat_reads", issued_reads_o, 32'(exp_reads));
            check("stat_writes", issued_writes_o, 32'(exp_writes));
`endif
        end
    endtask

    initial begin
        reset = 1'b1;
        load_valid_i = 1'b0; load_rw_i = 1'b0; load_addr_i = '0;
        start_i = 1'b0; loops_i = '0; clear_i = 1'b0;
        #2;
        check("rst_req_valid", 32'(req_valid_o), 32'd0);
        check("rst_req_word", 32'({req_rw_o, req_addr_o}), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_load_ready", 32'(load_ready_o), 32'd1);

        // Three-entry trace, full-rate acceptance
        load(1'b1, 16'h0010); load(1'b0, 16'h0010); load(1'b0, 16'h4010);
        check("count3", 32'(count_o), 32'd3);
        start_play(1);
        wait_done();

        // Same trace with entry 1 held under four cycles of backpressure
        do_clear();
        load(1'b1, 16'h0010); load(1'b0, 16'h0010); load(1'b0, 16'h4010);
        ready_mode  = 3;
        req_ready_i = 1'b1;
        start_play(1);
        step();
        req_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("bp_valid", 32'(req_valid_o), 32'd1);
            check("bp_addr", 32'(req_addr_o), 32'h0010);
            check("bp_rw", 32'(req_rw_o), 32'd0);
        end
        req_ready_i = 1'b1;
        ready_mode  = 0;
        wait_done();

        // Two entries replayed twice, no bubble at the wrap
        do_clear();
        load(1'b0, 16'h1000); load(1'b1, 16'h2000);
        start_play(2);
        wait_done();

        // Fill to capacity, then one extra load
        do_clear();
        for (int i = 0; i < DEPTH; i++) load(1'($urandom), AW'($urandom));
        check("full_load_ready", 32'(load_ready_o), 32'd0);
        load(1'b1, 16'hBEEF);
        check("full_overflow", 32'(overflow_o), 32'd1);
        check("full_count", 32'(count_o), 32'(DEPTH));
        ready_mode = 1;
        start_play(1);
        wait_done();
        ready_mode = 0;

        // Start on an empty buffer
        do_clear();
        start_play(1);
        check("empty_done", 32'(done_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("empty_no_req", 32'(req_valid_o), 32'd0);
        end

        // Reset two cycles into playback
        do_clear();
        for (int i = 0; i < 6; i++) load(1'($urandom), AW'($urandom));
        start_play(3);
        step();
        #2;
        reset = 1'b1;
        #1;
        check("arst_req_valid", 32'(req_valid_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_count", 32'(count_o), 32'd0);
        exp_q.delete();
        trace_m.delete();
        ovf_m = 1'b0;
        step();
        reset = 1'b0;
        step();
        load(1'b0, 16'h0ABC); load(1'b1, 16'h0DEF);
        start_play(1);
        wait_done();

        // Randomised trials with backpressure, pause, load+start and replay from DONE
        ready_mode = 1;
        pause_mode = 1;
        for (int t = 0; t < 6; t++) begin
            int n;
            do_clear();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n - 1; i++) load(1'($urandom), AW'($urandom));
            if (t % 2 == 1) begin
                load_start(1'($urandom), AW'($urandom), $urandom_range(0, 3));
            end else begin
                load(1'($urandom), AW'($urandom));
                start_play($urandom_range(0, 3));
            end
            wait_done();
            start_play($urandom_range(0, 2));
            wait_done();
        end
        ready_mode = 0;
        pause_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cache_trace_player.md
Name: cache_trace_player

Overview:
- Transmit end of the cache access-request interface: buffers a trace of (rw, address) accesses and replays it, one request per accepted handshake, into the cache simulator.
- Sits between testbench/trace-file loader and the cache model.
- Supports replay loops, pause, backpressure and end-of-trace signalling, so cache statistics runs are cycle-deterministic.

Parameters:
ADDRESS_SIZE, 16, width of request address; must match the cache simulator.
DEPTH, 256, trace buffer entries; power of 2, 2..65536.
LOOPS_WIDTH, 8, width of loop-count input.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
load_valid  input  1  trace entry presented for loading.
load_rw  input  1  entry access type: 0 = read, 1 = write.
load_addr  input  ADDRESS_SIZE  entry address.
load_ready  output  1  buffer accepts an entry this cycle.
start  input  1  begin playback (single-cycle pulse or level; sampled per cycle).
loops  input  LOOPS_WIDTH  number of full passes; sampled at start; 0 is treated as 1.
pause  input  1  inhibit issuing new requests.
clear  input  1  empty the buffer.
req_valid  output  1  request valid to cache.
req_rw  output  1  request type.
req_addr  output  ADDRESS_SIZE  request address.
req_ready  input  1  cache accepts the request.
busy  output  1  high in PLAY.
done  output  1  high in DONE.
count  output  $clog2(DEPTH)+1  number of loaded entries.
overflow  output  1  sticky: a load was attempted while the buffer was full.

Behaviour:
- Reset (async, immediate): state IDLE; req_valid, req_rw, req_addr, busy, done, overflow, count = 0; buffer pointers = 0. Buffer contents are don't-care.
- Transfer = req_valid && req_ready at a rising clk edge.
- FSM states: IDLE, PLAY, DONE.
- IDLE:
  - load_ready = (count < DEPTH).
  - load_valid && load_ready: store the entry at index count; count increments.
  - load_valid while full: entry dropped; overflow set.
  - start && count > 0 -> PLAY: loop counter = max(loops, 1); read pointer = 0.
  - start && count == 0 -> DONE.
  - load and start in the same cycle: the load is accepted and included in playback.
- load_ready = 0 outside IDLE; loads outside IDLE are ignored and do not set overflow.
- PLAY:
  - First req_valid is asserted in the cycle after start is sampled, carrying entry 0.
  - After each transfer, the next entry is presented in the following cycle, so a held req_ready gives 1 transfer per cycle.
  - Once req_valid is high, req_valid, req_rw and req_addr hold stable until a transfer occurs. pause never retracts an outstanding request.
  - pause = 1 prevents req_valid rising for the next entry; when pause falls, req_valid rises the next cycle.
  - Transfer of the last entry (read pointer == count-1):
    - loop counter > 1: read pointer wraps to 0; loop counter decrements; playback continues with no bubble.
    - otherwise: go to DONE; req_valid is 0 in the next cycle.
  - start and clear are ignored in PLAY.
- DONE:
  - done = 1.
  - start -> PLAY and replays the same buffer with new loops.
  - clear -> IDLE.
- clear in IDLE or DONE: count = 0, overflow = 0, go to IDLE. If clear and start are asserted together, clear wins.
- Reset mid-PLAY: req_valid drops asynchronously; the in-flight request is abandoned.

Optional Feature:
CACHE_TRACE_STATS_EN:
- Defined: adds outputs issued_reads[31:0], issued_writes[31:0]. Each increments per transfer according to req_rw and saturates at 2^32-1. Both are cleared by reset and by start accepted from IDLE or DONE.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package cache_sim_pkg:
  - u16/u32/u64 typedefs.
  - trace_entry_t packed struct {rw, addr[ADDRESS_SIZE-1:0]}, parameterised via package localparam default 16.
  - player_state_t enum {IDLE, PLAY, DONE}.
- Sub-module trace_buffer: simple dual-port memory, DEPTH x trace_entry_t, synchronous write, registered read. The player prefetches so back-to-back issue has no bubble.

Test Plan:
- Load W 0x0010, R 0x0010, R 0x4010; loops=1; req_ready=1; start -> req transfers on 3 consecutive cycles with exactly those values; done=1 the cycle after the last; count=3.
- Same trace; drop req_ready for 4 cycles while the entry-1 request is valid -> req_addr holds 0x0010 and req_rw holds 0 all 4 cycles; no skipped or duplicated entry.
- 2 entries (R 0x1000, W 0x2000); loops=2 -> sequence 0x1000, 0x2000, 0x1000, 0x2000 with no bubble at wrap; then DONE; busy low.
- Load DEPTH entries then one more -> load_ready=0 at full; overflow=1; count=DEPTH; playback issues exactly DEPTH requests.
- start with count=0 -> done=1 the next cycle; req_valid never asserts. Assert pause mid-play with the request accepted -> no new req_valid until pause falls.
- Assert reset 2 cycles into PLAY -> req_valid, busy, count drop to 0 without waiting for a clk edge; a subsequent load and start play correctly.
